// File: rtl/mult_ctrl.sv
// ----------------------------------------------------------------------------
// mult_ctrl
//   Sequencer between the EX stage and the iterative Booth multiplier for
//   MULT/MULTU. It accepts one request, stalls the front of the pipeline,
//   drives the multiplier, applies the unsigned correction for MULTU and
//   commits the 64-bit product into the HI/LO registers it owns. MTHI/MTLO
//   writes land here too, and HI/LO are exposed for MFHI/MFLO.
//
//   Optional feature macro: MULT_TIMEOUT_EN
//     defined   -> BUSY watchdog; after TIMEOUT_CYCLES BUSY cycles without
//                  booth_done the op is abandoned and mult_err sets (sticky).
//     undefined -> BUSY waits forever, mult_err is tied to 0.
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     ex_mult_req          EX holds a MULT/MULTU
//     ex_mult_signed       1 = MULT, 0 = MULTU
//     ex_op1, ex_op2       rs / rt operands
//     flush                cancel any operation (exception / eret)
//     hilo_we, hilo_wdata  MTHI (bit1) / MTLO (bit0) write from WB
//     booth_start/op1/op2  multiplier start and operands
//     booth_done/result    multiplier completion and signed 64-bit product
//     stall_req            hold PC/IF/ID/EX
//     busy                 FSM not idle
//     hi_o, lo_o           HI / LO registers
//     mult_err             sticky watchdog error
// ----------------------------------------------------------------------------
module mult_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mult_req,
    input  logic        ex_mult_signed,
    input  logic [31:0] ex_op1,
    input  logic [31:0] ex_op2,
    input  logic        flush,
    input  logic [1:0]  hilo_we,
    input  logic [31:0] hilo_wdata,
    output logic        booth_start,
    output logic [31:0] booth_op1,
    output logic [31:0] booth_op2,
    input  logic        booth_done,
    input  logic [63:0] booth_result,
    output logic        stall_req,
    output logic        busy,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        mult_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic        signed_q;
    logic [63:0] prod_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        accept;
    logic [31:0] corr;
    logic [31:0] fix_hi;

`ifdef MULT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;
`endif

    // The request is taken in the same cycle it shows up, so the stall has
    // to be raised combinationally from the request itself.
    assign accept = (state == IDLE) && ex_mult_req && !flush && !rst;

    // flush and rst kill stall/start immediately, not one cycle later.
    assign stall_req   = !rst && !flush && (accept || state == BUSY || state == FIX);
    assign booth_start = !rst && !flush && (state == BUSY);

    // Operands come straight from the latched copies, so they stay put for
    // the whole BUSY window regardless of what EX does.
    assign booth_op1 = op1_q;
    assign booth_op2 = op2_q;
    assign busy      = (state != IDLE);
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

    // The multiplier always treats its operands as signed. For MULTU each
    // operand with bit 31 set was read as (x - 2^32); adding the other
    // operand into HI undoes that. The 2^64 cross term drops out mod 2^64.
    always_comb begin
        corr = '0;
        if (!signed_q) begin
            if (op1_q[31]) corr = corr + op2_q;
            if (op2_q[31]) corr = corr + op1_q;
        end
    end

    assign fix_hi = prod_q[63:32] + corr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            signed_q <= 1'b0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULT_TIMEOUT_EN
            wd_cnt   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // MTHI/MTLO land in any state. The FIX commit below is written
            // later in this block, so it overrides a same-cycle MTHI/MTLO:
            // the MULT is younger in program order.
            if (hilo_we[1]) hi_q <= hilo_wdata;
            if (hilo_we[0]) lo_q <= hilo_wdata;

            if (flush) begin
                // Abandon whatever is in flight; a late booth result is
                // simply never captured and HI/LO are left alone.
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (ex_mult_req) begin
                            op1_q    <= ex_op1;
                            op2_q    <= ex_op2;
                            signed_q <= ex_mult_signed;
`ifdef MULT_TIMEOUT_EN
                            wd_cnt   <= '0;
`endif
                            state    <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (booth_done) begin
                            prod_q <= booth_result;
                            state  <= FIX;
                        end
`ifdef MULT_TIMEOUT_EN
                        else if (wd_cnt == WD_LAST) begin
                            // Give up: release the pipeline without touching HI/LO.
                            err_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
`endif
                    end
                    FIX: begin
                        hi_q  <= fix_hi;
                        lo_q  <= prod_q[31:0];
                        state <= DONE;
                    end
                    DONE: begin
                        // The MULT is still sitting in EX this cycle, so its
                        // request is ignored to avoid re-issuing it.
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef MULT_TIMEOUT_EN
    assign mult_err = err_q;
`else
    assign mult_err = 1'b0;
    // Watchdog sizing only matters when the watchdog is built in.
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > CNT_W);
`endif

endmodule
